// File: rtl/onectr_seq_multimode.sv
// -----------------------------------------------------------------------------
// onectr_seq_multimode
//
// Sequential bit-counting engine. An INPUTSIZE-bit operand is scanned STEP bits
// per cycle, LSB-first, and one of four counts is accumulated:
//   mode 00 : number of ones
//   mode 01 : number of zeros
//   mode 10 : leading zeros (operand is bit-reversed on capture, so the scan
//             is still LSB-first)
//   mode 11 : trailing zeros
//
// Flow: IDLE (ready_o=1) -> RUN (INPUTSIZE/STEP cycles) -> DONE (done_o pulse)
// -> IDLE. start_i during RUN/DONE is ignored.
//
// Optional feature: define ONECTR_EARLY_EXIT_EN to let RUN finish as soon as
// the result can no longer change (mode 00: remaining bits all zero; modes
// 10/11: first set bit found). Results are identical either way; only the
// latency and cycles_o differ.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, priority over everything
//   start_i   in   operation request, sampled only while ready_o=1
//   mode_i    in   count select, sampled with start_i
//   InPort    in   operand, sampled with start_i
//   ready_o   out  high in IDLE
//   done_o    out  one-cycle pulse, OutPort/cycles_o valid
//   OutPort   out  count result, held until the next done_o
//   cycles_o  out  RUN cycles used by the last operation
// -----------------------------------------------------------------------------
module onectr_seq_multimode #(
  parameter int INPUTSIZE = 64,
  parameter int STEP      = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start_i,
  input  logic [1:0]                                       mode_i,
  input  logic [INPUTSIZE-1:0]                             InPort,
  output logic                                             ready_o,
  output logic                                             done_o,
  output logic [$clog2(INPUTSIZE+1)-1:0]                   OutPort,
  output logic [$clog2((INPUTSIZE/STEP)+1)-1:0]            cycles_o
);

  localparam int N  = INPUTSIZE / STEP;
  localparam int OW = $clog2(INPUTSIZE + 1);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    M_ONES  = 2'b00,
    M_ZEROS = 2'b01,
    M_LZ    = 2'b10,
    M_TZ    = 2'b11
  } mode_e;

  // Number of set bits in one chunk.
  function automatic logic [OW-1:0] chunk_popcount(input logic [STEP-1:0] c);
    logic [OW-1:0] n;
    n = '0;
    for (int i = 0; i < STEP; i++) begin
      n = n + OW'(c[i]);
    end
    return n;
  endfunction

  // Trailing zeros of one chunk; an all-zero chunk counts as STEP.
  function automatic logic [OW-1:0] chunk_tz(input logic [STEP-1:0] c);
    logic [OW-1:0] n;
    n = OW'(STEP);
    // Scanning downwards leaves the lowest set bit's index as the answer.
    for (int i = STEP - 1; i >= 0; i--) begin
      if (c[i]) begin
        n = OW'(i);
      end
    end
    return n;
  endfunction

  state_e                 state_q, state_d;
  mode_e                  mode_q,  mode_d;
  logic [INPUTSIZE-1:0]   shreg_q, shreg_d;
  logic [OW-1:0]          acc_q,   acc_d;
  logic [CW-1:0]          cnt_q,   cnt_d;
  logic                   stop_q,  stop_d;
  logic [OW-1:0]          out_q,   out_d;
  logic [CW-1:0]          cycles_q, cycles_d;

  logic [INPUTSIZE-1:0]   in_rev;
  logic [STEP-1:0]        chunk;
  logic [OW-1:0]          contrib;
  logic                   zero_scan;
  logic                   early;
`ifdef ONECTR_EARLY_EXIT_EN
  logic [INPUTSIZE-1:0]   rest;
`endif

  // Leading-zero mode is turned into a trailing-zero scan by reversing bits.
  always_comb begin
    for (int i = 0; i < INPUTSIZE; i++) begin
      in_rev[i] = InPort[INPUTSIZE-1-i];
    end
  end

  assign chunk     = shreg_q[STEP-1:0];
  assign zero_scan = (mode_q == M_LZ) || (mode_q == M_TZ);

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    out_d    = out_q;
    cycles_d = cycles_q;
    contrib  = '0;
    early    = 1'b0;
`ifdef ONECTR_EARLY_EXIT_EN
    rest     = shreg_q >> STEP;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          shreg_d = (mode_i == 2'b10) ? in_rev : InPort;
          mode_d  = mode_e'(mode_i);
          acc_d   = '0;
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        case (mode_q)
          M_ONES:  contrib = chunk_popcount(chunk);
          M_ZEROS: contrib = OW'(STEP) - chunk_popcount(chunk);
          default: begin
            // Once the first set bit is seen the count is frozen.
            if (!stop_q) begin
              contrib = chunk_tz(chunk);
            end
          end
        endcase

        if (zero_scan && !stop_q && (chunk != '0)) begin
          stop_d = 1'b1;
        end

        acc_d   = acc_q + contrib;
        shreg_d = shreg_q >> STEP;
        cnt_d   = cnt_q + 1'b1;

`ifdef ONECTR_EARLY_EXIT_EN
        early = ((mode_q == M_ONES) && (rest == '0)) ||
                (zero_scan && !stop_q && (chunk != '0));
`endif

        if ((cnt_q == CW'(N - 1)) || early) begin
          out_d    = acc_d;
          cycles_d = cnt_q + 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      stop_q   <= 1'b0;
      out_q    <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      stop_q   <= stop_d;
      out_q    <= out_d;
      cycles_q <= cycles_d;
    end
  end

  // NOTE: the operand shift register and mode are pure datapath, always
  // loaded on start before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    mode_q  <= mode_d;
  end

  assign ready_o  = (state_q == S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign OutPort  = out_q;
  assign cycles_o = cycles_q;

endmodule

// File: tb/tb_onectr_seq_multimode.sv
// -----------------------------------------------------------------------------
// Testbench for onectr_seq_multimode (INPUTSIZE=64, STEP=4).
// A driver issues operations and pushes the expected result, cycle count and
// done cycle into a queue; an independent monitor pops on every done_o and
// also checks that OutPort/cycles_o hold steady between completions.
// -----------------------------------------------------------------------------
module tb_onectr_seq_multimode;

  localparam int W  = 64;
  localparam int S  = 4;
  localparam int NC = W / S;

  typedef struct {
    int      out;
    int      cycles;
    longint  done_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic [W-1:0]  InPort = '0;
  logic          ready_o;
  logic          done_o;
  logic [6:0]    OutPort;
  logic [4:0]    cycles_o;

  onectr_seq_multimode #(.INPUTSIZE(W), .STEP(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .InPort   (InPort),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .OutPort  (OutPort),
    .cycles_o (cycles_o)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  exp_t   exp_q[$];
  bit     mon_en = 1'b0;
  bit     rst_at_edge = 1'b1;
  int     last_out = 0;
  int     last_cycles = 0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (behavioural) ----------------
  function automatic int lz_of(input logic [W-1:0] op);
    for (int i = W - 1; i >= 0; i--) if (op[i]) return W - 1 - i;
    return W;
  endfunction

  function automatic int tz_of(input logic [W-1:0] op);
    for (int i = 0; i < W; i++) if (op[i]) return i;
    return W;
  endfunction

  function automatic int m_out(input logic [W-1:0] op, input logic [1:0] md);
    case (md)
      2'b00:   return $countones(op);
      2'b01:   return W - $countones(op);
      2'b10:   return lz_of(op);
      default: return tz_of(op);
    endcase
  endfunction

  function automatic int m_cycles(input logic [W-1:0] op, input logic [1:0] md);
`ifdef ONECTR_EARLY_EXIT_EN
    case (md)
      2'b00:   return (op == '0) ? 1 : ((W - 1 - lz_of(op)) / S + 1);
      2'b01:   return NC;
      2'b10:   return (op == '0) ? NC : (lz_of(op) / S + 1);
      default: return (op == '0) ? NC : (tz_of(op) / S + 1);
    endcase
`else
    return NC;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (rst_at_edge) begin
        last_out    = 0;
        last_cycles = 0;
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no operation pending (OutPort=%0d, t=%0t)",
                   OutPort, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", OutPort, e.out);
          check("cycles", cycles_o, e.cycles);
          check("done_cycle", cyc, e.done_cyc);
          last_out    = e.out;
          last_cycles = e.cycles;
        end
      end else begin
        check("out_hold", OutPort, last_out);
        check("cycles_hold", cycles_o, last_cycles);
      end
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge; returns on the negedge after acceptance.
  task automatic issue(input logic [W-1:0] op, input logic [1:0] md,
                       input bit push, input bit hold, output longint acc_k);
    int waited = 0;
    InPort  = op;
    mode_i  = md;
    start_i = 1'b1;
    acc_k   = -1;
    while (!ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=0 for %0d cycles expected 1", waited);
      start_i = 1'b0;
      return;
    end
    acc_k = cyc;
    if (push) begin
      exp_t e;
      e.out      = m_out(op, md);
      e.cycles   = m_cycles(op, md);
      e.done_cyc = cyc + e.cycles + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    InPort = {$urandom, $urandom};
    mode_i = 2'($urandom_range(0, 3));
  endtask

  longint k, prev_k;
  int     prev_cyc;
  logic [W-1:0] op;
  logic [1:0]   md;

  initial begin
    // Reset held for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_out", OutPort, 0);
    check("rst_cycles", cycles_o, 0);
    mon_en = 1'b1;

    // Directed operations.
    issue(64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1, 0, k);
    issue(64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1, 0, k);
    issue(64'h0000_0000_0000_0100, 2'b11, 1, 0, k);
    issue(64'h0000_0000_0000_0100, 2'b10, 1, 0, k);
    for (int m = 0; m < 4; m++) issue('0, 2'(m), 1, 0, k);
    issue(64'h8000_0000_0000_0001, 2'b00, 1, 0, k);

    // Abort in the 5th RUN cycle (mode 01 never exits early).
    issue(64'h0123_4567_89AB_CDEF, 2'b01, 0, 0, k);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", ready_o, 1);
    check("abort_out", OutPort, 0);
    check("abort_cycles", cycles_o, 0);

    // start_i pulsed during RUN must be ignored.
    issue(64'h00F0_0000_0000_0000, 2'b00, 1, 0, k);
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    InPort  = 64'hFFFF_FFFF_FFFF_FFFF;
    mode_i  = 2'b01;
    @(negedge clk);
    start_i = 1'b0;

    // Back-to-back with start_i held high.
    prev_k = -1;
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      op = (i % 2 == 0) ? 64'h1 : 64'h8000_0000_0000_0000;
      md = (i % 2 == 0) ? 2'b00 : 2'b10;
      issue(op, md, 1, 1, k);
      if (prev_k >= 0 && k >= 0) check("b2b_interval", k - prev_k, prev_cyc + 2);
      prev_k   = k;
      prev_cyc = m_cycles(op, md);
    end
    start_i = 1'b0;

    // Randomised operations with shaped operands.
    for (int i = 0; i < 40; i++) begin
      op = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: ;
        1: op = op >> $urandom_range(0, 63);
        2: op = op << $urandom_range(0, 63);
        default: op = ($urandom_range(0, 1) == 0) ? '0 : (64'h1 << $urandom_range(0, 63));
      endcase
      md = 2'($urandom_range(0, 3));
      issue(op, md, 1, ($urandom_range(0, 1) == 1), k);
      start_i = 1'b0;
    end

    // Drain outstanding expectations.
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
